// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback has priority, late results queue and drain into idle slots.
// Optional same-cycle late bypass into an idle port when WB_LATE_BYPASS_EN is defined.
module regs_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       p_we,
  input  logic [4:0]                 p_waddr,
  input  logic [31:0]                p_wdata,
  input  logic                       l_valid,
  output logic                       l_ready,
  input  logic [4:0]                 l_waddr,
  input  logic [31:0]                l_wdata,
  output logic                       we,
  output logic [4:0]                 waddr,
  output logic [31:0]                wdata,
  output logic [31:0]                busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_live;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;

  logic p_act;
  logic head_occ;
  logic head_live;
  logic accept;
  logic bypass;
  logic push;
  logic pop;

  assign p_act     = p_we & (p_waddr != '0);
  assign head_occ  = (cnt != '0);
  assign head_live = head_occ & q_live[rd_ptr];
  assign l_ready   = !rst & (cnt < CW'(DEPTH));
  assign accept    = l_valid & l_ready;

`ifdef WB_LATE_BYPASS_EN
  assign bypass = !rst & !head_occ & !p_act & l_valid & (l_waddr != '0);
`else
  assign bypass = 1'b0;
`endif

  // Zero-register results are handshaken but never stored; a bypassed result is already written.
  assign push  = accept & (l_waddr != '0) & !bypass;
  // A dead head leaves in any cycle; a live head only when the pipeline leaves the port free.
  assign pop   = head_occ & (!p_act | !head_live);
  assign count = cnt;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!rst) begin
      if (p_act) begin
        we    = 1'b1;
        waddr = p_waddr;
        wdata = p_wdata;
      end else if (head_live) begin
        we    = 1'b1;
        waddr = q_addr[rd_ptr];
        wdata = q_data[rd_ptr];
      end else if (bypass) begin
        we    = 1'b1;
        waddr = l_waddr;
        wdata = l_wdata;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) busy[q_addr[i]] = 1'b1;
    end
  end

  // Queue control: kill first, then pop, then push, so an entry written this edge stays live.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      q_live <= '0;
    end else begin
      if (p_act) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_addr[i] == p_waddr) q_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PW'(1);
      end
      if (push) begin
        q_live[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= l_waddr;
      q_data[wr_ptr] <= l_wdata;
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter: a queue-level reference model predicts writes and status, a monitor compares.
module tb_regs_wb_arbiter;

  localparam int DEPTH = 4;
`ifdef WB_LATE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_we = 1'b0;
  logic [4:0]  p_waddr = '0;
  logic [31:0] p_wdata = '0;
  logic        l_valid = 1'b0;
  logic        l_ready;
  logic [4:0]  l_waddr = '0;
  logic [31:0] l_wdata = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;
  logic [$clog2(DEPTH):0] count;

  regs_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .l_valid(l_valid), .l_ready(l_ready), .l_waddr(l_waddr), .l_wdata(l_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; bit live; } ent_t;
  typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit we; bit lr; int cnt; logic [31:0] busy; } st_t;

  ent_t mq[$];
  wr_t  wq[$];
  st_t  sq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask

  // Reference model: one cycle of the arbiter described as queue operations on the current inputs.
  task automatic step(output bit acc);
    st_t s;
    bit pact, lr, bp, hl, hd;
    s.busy = '0;
    foreach (mq[i]) if (mq[i].live) s.busy[mq[i].a] = 1'b1;
    s.cnt = mq.size();
    s.we  = 1'b0;
    acc   = 1'b0;
    if (rst) begin
      s.lr = 1'b0;
      mq.delete();
    end else begin
      pact = p_we && (p_waddr != 0);
      lr   = mq.size() < DEPTH;
      s.lr = lr;
      bp   = 1'b0;
      hl   = mq.size() > 0 && mq[0].live;
      hd   = mq.size() > 0 && !mq[0].live;
      if (pact) begin
        s.we = 1'b1;
        wq.push_back('{cyc, p_waddr, p_wdata});
      end else if (hl) begin
        s.we = 1'b1;
        wq.push_back('{cyc, mq[0].a, mq[0].d});
      end else if (BYP && mq.size() == 0 && l_valid && l_waddr != 0) begin
        s.we = 1'b1;
        bp   = 1'b1;
        wq.push_back('{cyc, l_waddr, l_wdata});
      end
      if (hd || (hl && !pact)) void'(mq.pop_front());
      if (pact) foreach (mq[i]) if (mq[i].a == p_waddr) mq[i].live = 1'b0;
      acc = l_valid && lr;
      if (acc && l_waddr != 0 && !bp) mq.push_back('{l_waddr, l_wdata, 1'b1});
    end
    sq.push_back(s);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit r, input bit pw, input logic [4:0] pa, input bit lv, input logic [4:0] la);
    rst     = r;
    p_we    = pw;
    p_waddr = pa;
    p_wdata = $urandom();
    l_valid = lv;
    l_waddr = la;
    l_wdata = $urandom();
  endtask

  // Monitor: status every cycle, and each presented write against the head of the expected-write queue.
  always @(negedge clk) begin
    if (started) begin
      if (sq.size() == 0) begin
        chk("status_underflow", 32'd1, 32'd0);
      end else begin
        st_t s;
        s = sq.pop_front();
        chk("we", {31'd0, we}, {31'd0, s.we});
        chk("l_ready", {31'd0, l_ready}, {31'd0, s.lr});
        chk("count", 32'(count), 32'(s.cnt));
        chk("busy", busy, s.busy);
      end
      if (we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {27'd0, waddr}, 32'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_cycle", 32'(cyc), 32'(w.cyc));
          chk("waddr", {27'd0, waddr}, {27'd0, w.a});
          chk("wdata", wdata, w.d);
        end
      end else begin
        chk("idle_waddr", {27'd0, waddr}, 32'd0);
        chk("idle_wdata", wdata, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k, i;
    @(posedge clk);
    #1;
    started = 1'b1;

    // Reset held two cycles with a late result offered.
    repeat (2) begin drive(1, 0, 0, 1, 5'd9); step(acc); end
    drive(0, 0, 0, 0, 0); step(acc);

    // Idle late write r5.
    drive(0, 0, 0, 1, 5'd5); l_wdata = 32'h0000_1234; step(acc);
    repeat (3) begin drive(0, 0, 0, 0, 0); step(acc); end

    // Contention: pipeline r1..r6 while pushing r8..r12.
    k = 8;
    i = 0;
    while ((i < 6 || k <= 12) && i < 40) begin
      drive(0, i < 6, 5'(i + 1), k <= 12, 5'(k));
      step(acc);
      if (acc && k <= 12) k++;
      i++;
    end
    repeat (6) begin drive(0, 0, 0, 0, 0); step(acc); end

    // Kill: r7=AAAA queued behind a pipeline write, then pipeline writes r7=BBBB.
    drive(0, 1, 5'd1, 1, 5'd7); l_wdata = 32'h0000_AAAA; step(acc);
    drive(0, 1, 5'd7, 0, 0);    p_wdata = 32'h0000_BBBB; step(acc);
    repeat (3) begin drive(0, 0, 0, 0, 0); step(acc); end

    // Zero register late result.
    drive(0, 0, 0, 1, 5'd0); step(acc);
    repeat (2) begin drive(0, 0, 0, 0, 0); step(acc); end

    // Reset mid-drain with three live entries.
    for (int j = 0; j < 3; j++) begin drive(0, 1, 5'd1, 1, 5'(3 + j)); step(acc); end
    drive(1, 0, 0, 0, 0); step(acc);
    repeat (5) begin drive(0, 0, 0, 0, 0); step(acc); end

    // Randomized traffic over a small register range to provoke kills and same-edge collisions.
    repeat (2000) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
      step(acc);
    end
    repeat (DEPTH + 4) begin drive(0, 0, 0, 0, 0); step(acc); end

    started = 1'b0;
    chk("writes_left", 32'(wq.size()), 32'd0);
    chk("status_left", 32'(sq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
